// File: rtl/rtc_pkg.sv
// Shared constants and helpers for the real-time clock BCD datapath.
package rtc_pkg;

   localparam int unsigned DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] MOD2  = 4'd2;
   localparam logic [DIGIT_W-1:0] MOD3  = 4'd3;
   localparam logic [DIGIT_W-1:0] MOD4  = 4'd4;
   localparam logic [DIGIT_W-1:0] MOD6  = 4'd6;
   localparam logic [DIGIT_W-1:0] MOD10 = 4'd10;

   // A digit modulus is usable only within 2..10.
   function automatic logic mode_legal(input logic [DIGIT_W-1:0] m);
      return (m >= MOD2) && (m <= MOD10);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with programmable modulus; stepping is decided by the chain above it.
module bcd_digit
   import rtc_pkg::*;
(
   input  logic               clk,
   input  logic               rset_n,
   input  logic               step,
   input  logic               up,
   input  logic [DIGIT_W-1:0] mode,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_val,
   input  logic [DIGIT_W-1:0] force_val,
   input  logic               force_en,
   output logic [DIGIT_W-1:0] value,
   output logic               term_up,
   output logic               term_dn,
   output logic               illegal
);

   logic [DIGIT_W-1:0] value_q;
   logic [DIGIT_W-1:0] value_d;
   logic [DIGIT_W-1:0] max_c;
   logic               legal_c;

   // Terminal detection; an illegal digit is transparent to carry and borrow.
   always_comb begin
      legal_c = mode_legal(mode);
      max_c   = mode - DIGIT_W'(1);
      term_up = !legal_c || (value_q >= max_c);
      term_dn = !legal_c || (value_q == '0);
      illegal = !legal_c;
   end

   // Next value: illegal clear, then load, then chain-wide force, then step.
   always_comb begin
      value_d = value_q;
      if (!legal_c) begin
         value_d = '0;
      end else if (load) begin
         value_d = (load_val < mode) ? load_val : '0;
      end else if (force_en) begin
         value_d = force_val;
      end else if (step) begin
         if (up) begin
            value_d = (value_q >= max_c) ? '0 : value_q + DIGIT_W'(1);
         end else begin
            value_d = ((value_q == '0) || (value_q > max_c)) ? max_c : value_q - DIGIT_W'(1);
         end
      end
   end

   // Digit state register.
   always_ff @(posedge clk or negedge rset_n) begin
      if (!rset_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/bcd_chain_counter.sv
// Multi-digit BCD counter chain with per-digit modulus, up/down, preset load and wrap limit.
module bcd_chain_counter
   import rtc_pkg::*;
#(
   parameter int unsigned DIGITS = 2
) (
   input  logic                      clk,
   input  logic                      rset_n,
   input  logic                      en,
   input  logic                      up,
   input  logic                      load,
   input  logic [DIGIT_W*DIGITS-1:0] load_val,
   input  logic [DIGIT_W*DIGITS-1:0] mode,
   input  logic                      limit_en,
   input  logic [DIGIT_W*DIGITS-1:0] limit,
   output logic [DIGIT_W*DIGITS-1:0] count,
   output logic                      ov,
   output logic                      uf,
   output logic                      err
);

   localparam int unsigned CW = DIGIT_W * DIGITS;

   logic [DIGITS-1:0] term_up_c;
   logic [DIGITS-1:0] term_dn_c;
   logic [DIGITS-1:0] illegal_c;
   logic [DIGITS-1:0] reject_c;
   logic [DIGITS-1:0] step_c;
   logic [DIGITS:0]   carry_c;
   logic [DIGITS:0]   borrow_c;
   logic [CW-1:0]     force_val_c;
   logic              tick_c;
   logic              limit_hit_c;
   logic              force_c;

   logic ov_q, ov_d;
   logic uf_q, uf_d;
   logic err_q, err_d;

   // Carry/borrow into digit i is the AND of the terminal flags of all lower digits.
   assign carry_c[0]  = 1'b1;
   assign borrow_c[0] = 1'b1;
   for (genvar i = 1; i <= DIGITS; i++) begin : g_chain
      assign carry_c[i]  = &term_up_c[i-1:0];
      assign borrow_c[i] = &term_dn_c[i-1:0];
   end

   // Per-digit step, force value and load rejection.
   always_comb begin
      step_c      = '0;
      force_val_c = '0;
      reject_c    = '0;
      tick_c      = en && !load;
      limit_hit_c = limit_en && (count == limit);
      force_c     = tick_c && ((up && limit_hit_c) || (!up && borrow_c[DIGITS] && limit_en));
      for (int i = 0; i < int'(DIGITS); i++) begin
         step_c[i] = tick_c && (up ? carry_c[i] : borrow_c[i]);
         force_val_c[DIGIT_W*i +: DIGIT_W] = up ? DIGIT_W'(0) : limit[DIGIT_W*i +: DIGIT_W];
         reject_c[i] = load_val[DIGIT_W*i +: DIGIT_W] >= mode[DIGIT_W*i +: DIGIT_W];
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [DIGIT_W-1:0] value_c;

      bcd_digit u_digit (
         .clk       (clk),
         .rset_n    (rset_n),
         .step      (step_c[i]),
         .up        (up),
         .mode      (mode[DIGIT_W*i +: DIGIT_W]),
         .load      (load),
         .load_val  (load_val[DIGIT_W*i +: DIGIT_W]),
         .force_val (force_val_c[DIGIT_W*i +: DIGIT_W]),
         .force_en  (force_c),
         .value     (value_c),
         .term_up   (term_up_c[i]),
         .term_dn   (term_dn_c[i]),
         .illegal   (illegal_c[i])
      );

      assign count[DIGIT_W*i +: DIGIT_W] = value_c;
   end

   // Wrap pulses and configuration error for the coming cycle.
   always_comb begin
      ov_d  = tick_c && up && (limit_hit_c || carry_c[DIGITS]);
      uf_d  = tick_c && !up && borrow_c[DIGITS];
      err_d = (|illegal_c) || (load && (|reject_c));
   end

   // Flag registers.
   always_ff @(posedge clk or negedge rset_n) begin
      if (!rset_n) begin
         ov_q  <= 1'b0;
         uf_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ov_q  <= ov_d;
         uf_q  <= uf_d;
         err_q <= err_d;
      end
   end

   assign ov  = ov_q;
   assign uf  = uf_q;
   assign err = err_q;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Bench for bcd_chain_counter: vector table plus scoreboard, with hand sequences for carry and reset.
module tb_bcd_chain_counter;

   typedef struct {
      string      name;
      logic       en;
      logic       up;
      logic       load;
      logic [7:0] lv;
      logic [7:0] mode;
      logic       lim_en;
      logic [7:0] lim;
      logic [7:0] cnt;
      logic       ov;
      logic       uf;
      logic       err;
   } vec_t;

   typedef struct {
      string       name;
      logic [7:0]  cnt;
      logic        ov;
      logic        uf;
      logic        err;
      logic        chk3;
      logic [11:0] cnt3;
      logic        err3;
   } exp_t;

   logic        clk;
   logic        rset_n;
   logic        en;
   logic        up;
   logic        load;
   logic [7:0]  load_val;
   logic [7:0]  mode;
   logic        limit_en;
   logic [7:0]  limit;
   logic [7:0]  count;
   logic        ov;
   logic        uf;
   logic        err;

   logic [11:0] load_val3;
   logic [11:0] mode3;
   logic [11:0] limit3;
   logic [11:0] count3;
   logic        ov3;
   logic        uf3;
   logic        err3;

   int   n_cmp;
   int   n_fail;
   exp_t sb[$];
   vec_t tbl[$];

   bcd_chain_counter #(.DIGITS(2)) dut (
      .clk      (clk),
      .rset_n   (rset_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
      .limit_en (limit_en),
      .limit    (limit),
      .count    (count),
      .ov       (ov),
      .uf       (uf),
      .err      (err)
   );

   bcd_chain_counter #(.DIGITS(3)) dut3 (
      .clk      (clk),
      .rset_n   (rset_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val3),
      .mode     (mode3),
      .limit_en (limit_en),
      .limit    (limit3),
      .count    (count3),
      .ov       (ov3),
      .uf       (uf3),
      .err      (err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input string n, input logic e, input logic u, input logic l,
                               input logic [7:0] lv, input logic [7:0] md, input logic le,
                               input logic [7:0] lm, input logic [7:0] c, input logic o,
                               input logic f, input logic r);
      vec_t v;
      v.name = n; v.en = e; v.up = u; v.load = l; v.lv = lv; v.mode = md;
      v.lim_en = le; v.lim = lm; v.cnt = c; v.ov = o; v.uf = f; v.err = r;
      return v;
   endfunction

   task automatic cmp(input string name, input string field, input logic [11:0] act,
                      input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
      end
   endtask

   // Pop the oldest expectation and compare it with what the DUTs show now.
   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         cmp(e.name, "count", 12'(count), 12'(e.cnt));
         cmp(e.name, "ov",    12'(ov),    12'(e.ov));
         cmp(e.name, "uf",    12'(uf),    12'(e.uf));
         cmp(e.name, "err",   12'(err),   12'(e.err));
         if (e.chk3) begin
            cmp(e.name, "count3", count3,   e.cnt3);
            cmp(e.name, "err3",   12'(err3), 12'(e.err3));
            cmp(e.name, "ov3",    12'(ov3),  12'(0));
            cmp(e.name, "uf3",    12'(uf3),  12'(0));
         end
      end
   endtask

   // Apply one vector for one clock, queue its expectation, check after the edge.
   task automatic drive(input vec_t v, input logic chk3 = 1'b0,
                        input logic [11:0] cnt3 = 12'h0, input logic e3 = 1'b0);
      exp_t e;
      en       = v.en;
      up       = v.up;
      load     = v.load;
      load_val = v.lv;
      mode     = v.mode;
      limit_en = v.lim_en;
      limit    = v.lim;
      e.name = v.name; e.cnt = v.cnt; e.ov = v.ov; e.uf = v.uf; e.err = v.err;
      e.chk3 = chk3; e.cnt3 = cnt3; e.err3 = e3;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      rset_n    = 1'b0;
      en        = 1'b0;
      up        = 1'b1;
      load      = 1'b0;
      load_val  = 8'h00;
      mode      = 8'h6A;
      limit_en  = 1'b0;
      limit     = 8'h23;
      load_val3 = 12'h000;
      mode3     = 12'hAAA;
      limit3    = 12'h000;

      // Name, en, up, load, load_val, mode, limit_en, limit, count, ov, uf, err
      tbl.push_back(mk("h_load22",   0, 1, 1, 8'h22, 8'h3A, 1, 8'h23, 8'h22, 0, 0, 0));
      tbl.push_back(mk("h_tick23",   1, 1, 0, 8'h00, 8'h3A, 1, 8'h23, 8'h23, 0, 0, 0));
      tbl.push_back(mk("h_limwrap",  1, 1, 0, 8'h00, 8'h3A, 1, 8'h23, 8'h00, 1, 0, 0));
      tbl.push_back(mk("h_reload",   0, 1, 1, 8'h22, 8'h3A, 0, 8'h23, 8'h22, 0, 0, 0));
      tbl.push_back(mk("h_nolim23",  1, 1, 0, 8'h00, 8'h3A, 0, 8'h23, 8'h23, 0, 0, 0));
      tbl.push_back(mk("h_nolim24",  1, 1, 0, 8'h00, 8'h3A, 0, 8'h23, 8'h24, 0, 0, 0));
      tbl.push_back(mk("h_hold",     0, 1, 0, 8'h00, 8'h3A, 0, 8'h23, 8'h24, 0, 0, 0));
      tbl.push_back(mk("d_load00",   0, 0, 1, 8'h00, 8'h6A, 0, 8'h23, 8'h00, 0, 0, 0));
      tbl.push_back(mk("d_uf59",     1, 0, 0, 8'h00, 8'h6A, 0, 8'h23, 8'h59, 0, 1, 0));
      tbl.push_back(mk("d_load00b",  0, 0, 1, 8'h00, 8'h6A, 1, 8'h23, 8'h00, 0, 0, 0));
      tbl.push_back(mk("d_uf_lim",   1, 0, 0, 8'h00, 8'h6A, 1, 8'h23, 8'h23, 0, 1, 0));
      tbl.push_back(mk("d_23_22",    1, 0, 0, 8'h00, 8'h6A, 1, 8'h23, 8'h22, 0, 0, 0));
      tbl.push_back(mk("d_load20",   0, 0, 1, 8'h20, 8'h6A, 0, 8'h23, 8'h20, 0, 0, 0));
      tbl.push_back(mk("d_borrow19", 1, 0, 0, 8'h00, 8'h6A, 0, 8'h23, 8'h19, 0, 0, 0));
      tbl.push_back(mk("l_rej_both", 1, 1, 1, 8'h7A, 8'h6A, 0, 8'h23, 8'h00, 0, 0, 1));
      tbl.push_back(mk("l_err_clr",  0, 1, 0, 8'h00, 8'h6A, 0, 8'h23, 8'h00, 0, 0, 0));
      tbl.push_back(mk("l_rej_hi",   0, 1, 1, 8'h75, 8'h6A, 0, 8'h23, 8'h05, 0, 0, 1));
      tbl.push_back(mk("l_win",      1, 1, 1, 8'h12, 8'h6A, 0, 8'h23, 8'h12, 0, 0, 0));
      tbl.push_back(mk("m_load45",   0, 1, 1, 8'h45, 8'h6A, 0, 8'h23, 8'h45, 0, 0, 0));
      tbl.push_back(mk("m_term_up",  1, 1, 0, 8'h00, 8'h63, 0, 8'h23, 8'h50, 0, 0, 0));
      tbl.push_back(mk("m_load05",   0, 1, 1, 8'h05, 8'h6A, 0, 8'h23, 8'h05, 0, 0, 0));
      tbl.push_back(mk("m_dn_clamp", 1, 0, 0, 8'h00, 8'h63, 0, 8'h23, 8'h02, 0, 0, 0));
      tbl.push_back(mk("a_load30",   0, 1, 1, 8'h30, 8'h6A, 1, 8'h23, 8'h30, 0, 0, 0));
      tbl.push_back(mk("a_step31",   1, 1, 0, 8'h00, 8'h6A, 1, 8'h23, 8'h31, 0, 0, 0));
      tbl.push_back(mk("a_load59",   0, 1, 1, 8'h59, 8'h6A, 1, 8'h23, 8'h59, 0, 0, 0));
      tbl.push_back(mk("a_wrap",     1, 1, 0, 8'h00, 8'h6A, 1, 8'h23, 8'h00, 1, 0, 0));
      tbl.push_back(mk("i_load39",   0, 1, 1, 8'h39, 8'h6A, 0, 8'h23, 8'h39, 0, 0, 0));
      tbl.push_back(mk("i_force",    0, 1, 0, 8'h00, 8'hCA, 0, 8'h23, 8'h09, 0, 0, 1));
      tbl.push_back(mk("i_hold",     0, 1, 0, 8'h00, 8'hCA, 0, 8'h23, 8'h09, 0, 0, 1));
      tbl.push_back(mk("i_legal",    0, 1, 0, 8'h00, 8'h6A, 0, 8'h23, 8'h09, 0, 0, 0));

      // Reset state while rset_n is held low.
      #2;
      cmp("reset", "count",  12'(count), 12'h000);
      cmp("reset", "ov",     12'(ov),    12'h000);
      cmp("reset", "uf",     12'(uf),    12'h000);
      cmp("reset", "err",    12'(err),   12'h000);
      cmp("reset", "count3", count3,     12'h000);
      @(posedge clk);
      #1;
      rset_n = 1'b1;

      // Minutes: 61 ticks from zero, one ov pulse on the 59 -> 00 step.
      for (int k = 1; k <= 61; k++) begin
         int m;
         m = k % 60;
         drive(mk($sformatf("min_%0d", k), 1, 1, 0, 8'h00, 8'h6A, 0, 8'h23,
                  8'((m / 10) * 16 + (m % 10)), (k == 60), 0, 0));
      end

      foreach (tbl[i]) drive(tbl[i]);

      // Illegal middle digit passes the carry to digit 2 in the 3-digit chain.
      load_val3 = 12'h039;
      mode3     = 12'hAAA;
      drive(mk("x_load", 0, 1, 1, 8'h39, 8'h6A, 0, 8'h23, 8'h39, 0, 0, 0), 1'b1, 12'h039, 1'b0);
      load_val3 = 12'h000;
      mode3     = 12'hACA;
      drive(mk("x_carry", 1, 1, 0, 8'h00, 8'h6A, 0, 8'h23, 8'h40, 0, 0, 0), 1'b1, 12'h100, 1'b1);
      mode3     = 12'hAAA;
      drive(mk("x_legal", 0, 1, 0, 8'h00, 8'h6A, 0, 8'h23, 8'h40, 0, 0, 0), 1'b1, 12'h100, 1'b0);

      // Asynchronous reset in the middle of a cycle, then counting resumes.
      drive(mk("r_load45", 0, 1, 1, 8'h45, 8'h6A, 0, 8'h23, 8'h45, 0, 0, 0));
      #2;
      rset_n = 1'b0;
      #1;
      cmp("areset", "count",  12'(count), 12'h000);
      cmp("areset", "ov",     12'(ov),    12'h000);
      cmp("areset", "uf",     12'(uf),    12'h000);
      cmp("areset", "err",    12'(err),   12'h000);
      cmp("areset", "count3", count3,     12'h000);
      @(negedge clk);
      rset_n = 1'b1;
      drive(mk("r_resume1", 1, 1, 0, 8'h00, 8'h6A, 0, 8'h23, 8'h01, 0, 0, 0));
      drive(mk("r_resume2", 1, 1, 0, 8'h00, 8'h6A, 0, 8'h23, 8'h02, 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_chain_counter.md
# bcd_chain_counter

Parametrised multi-digit BCD counter chain for the real-time clock datapath. Each digit has a runtime-programmable modulus from 2 to 10, and digits are chained ripple-free: carry and borrow are computed combinationally across the chain and registered in one clock. The block adds up/down counting, count enable, synchronous preset load, and an optional whole-chain wrap limit, such as 23 for hours. One instance replaces the separate seconds, minutes and hours digit counters.

## Interface
- `DIGITS`, default 2: number of BCD digits. Legal range is 1..8.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rset_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: count tick; one step per cycle while high.
- `up`  in  1: direction; 1 = increment, 0 = decrement.
- `load`  in  1: synchronous preset; has priority over `en`.
- `load_val`  in  4*DIGITS: preset value; digit i occupies bits [4i+3:4i].
- `mode`  in  4*DIGITS: per-digit modulus. Legal values are 2..10.
- `limit_en`  in  1: enables the chain wrap limit.
- `limit`  in  4*DIGITS: chain terminal value for up-count when `limit_en` = 1.
- `count`  out  4*DIGITS: registered count value.
- `ov`  out  1: registered one-cycle pulse on up-wrap to zero.
- `uf`  out  1: registered one-cycle pulse on down-wrap.
- `err`  out  1: registered config error flag.

## Operation
- **Reset:** `count` = 0, `ov` = 0, `uf` = 0, `err` = 0, applied immediately on `rset_n` low.
- **Priority** each cycle: `load`, then `en`, then hold. With `en` = 0 and `load` = 0, `count` holds and `ov`/`uf` = 0.
- **Load:**
  - Each digit takes its `load_val` digit.
  - A digit value ≥ its modulus loads 0 instead.
  - `ov`/`uf` = 0 on a load cycle.
- **Digit max:** max(i) = mode(i) − 1. A digit value ≥ max(i), for example after a mode change, is treated as terminal.
- **Up, `en` = 1:**
  - Digit i increments when every lower digit is terminal; digit 0 always steps.
  - A terminal digit that steps goes to 0.
  - If all digits are terminal, the whole chain becomes 0 and `ov` = 1.
- **Limit, up:**
  - If `limit_en` = 1 and `count` == `limit`, the whole chain becomes 0 and `ov` = 1.
  - Only exact equality triggers; a count above the limit runs to the natural wrap.
- **Down, `en` = 1:**
  - Digit i decrements when every lower digit is 0.
  - A digit at 0 that steps goes to max(i).
  - A digit with value > max(i) goes to max(i).
  - If all digits are 0, the chain becomes `limit` when `limit_en` = 1, otherwise every digit becomes max(i). `uf` = 1 in both cases.
- **Illegal mode (0, 1, 11..15):**
  - The digit is forced to 0 on the next edge.
  - The digit passes carry and borrow through unchanged.
  - `err` = 1.
- **`err`:** registered each cycle. Set if any `mode` digit is illegal, or if a load in that cycle rejected a digit. Otherwise 0.
- **`mode` and `limit` changes:** take effect on the next edge; there is no internal copy.

## Timing
- Latency from an input change to `count`, `ov`, `uf` and `err` is one clock.
- `ov`/`uf` go high in the same cycle that `count` shows the wrapped value, for exactly one cycle per wrap.
- Back-to-back wraps (DIGITS = 1, mode 2, `en` held high) give `ov` high every second cycle.
- `load` and `en` high together: the load wins and `en` is ignored for that cycle.
- `rset_n` asserted mid-count clears all state asynchronously. The first count happens on the first edge with `rset_n` high and `en` high.
- The carry chain is combinational across DIGITS. The critical path is O(DIGITS) and must meet timing at DIGITS = 8.

## Structure
- **Package `rtc_pkg`:**
  - BCD digit width constant (4).
  - Modulus constants: MOD2, MOD3, MOD4, MOD6, MOD10.
  - `mode_legal()` function.
- **Sub-module `bcd_digit`**, one per digit, generated DIGITS times:
  - Inputs: `step`, `up`, `mode`, `load`, `load_val`, `force_val`, `force`.
  - Outputs: `value`, `term_up`, `term_dn`, `illegal`.
- **Top level:** carry/borrow AND-chain, limit comparator, wrap muxing, and the `ov`/`uf`/`err` registers.

## Test plan
- **Minutes wrap:** DIGITS = 2, `mode` = {6,10}, `up` = 1, `en` held for 60 cycles from 0 → `count` = 0x59 on cycle 59, then 0x00 with a single `ov` pulse.
- **Hours limit:** `mode` = {3,10}, `limit` = 0x23, `limit_en` = 1, load 0x22, two `en` ticks → 0x23, then 0x00 with `ov` = 1. With `limit_en` = 0, the count proceeds 0x23 → 0x24.
- **Down underflow:** `mode` = {6,10}, `up` = 0, `count` = 0x00, one tick → 0x59 and `uf` = 1. With `limit_en` = 1 and `limit` = 0x23, the count goes to 0x23.
- **Load priority and rejection:** `load` and `en` both high, `load_val` = 0x7A with `mode` = {6,10} → `count` = 0x00 (both digits rejected), `err` = 1 for one cycle, no `ov`.
- **Illegal mode:** digit 1 `mode` = 12 while `count` = 0x39 → digit 1 becomes 0 and `err` stays 1. Carry from digit 0 passes through to digit 2 (DIGITS = 3).
- **Async reset:** assert `rset_n` low mid-cycle at `count` = 0x45 → `count` = 0 before the next edge, all flags 0, and counting resumes after release.
